sp_dram_arbiter: RTL and testbench

//   Shares the single 128-bit sp_dram user port between two requesters (P0, P1).

---
 rtl/sp_dram_arbiter_if.sv | 19 +
 rtl/sp_dram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sp_dram_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sp_dram_arbiter_if.sv
// sp_dram-style user port: request bus toward memory, full flag and read return back.
// The master drives requests; the slave accepts them and returns read data.
interface sp_dram_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MASK_WIDTH-1:0] mask;
  logic                  we;
  logic                  re;
  logic                  full;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ravail;

  modport master (output addr, wdata, mask, we, re, input full, rdata, ravail);
  modport slave  (input addr, wdata, mask, we, re, output full, rdata, ravail);
endinterface

// File: rtl/sp_dram_arbiter.sv
// Two-port round-robin arbiter in front of the sp_dram user port. Each port has a
// one-entry request buffer; a port-id tag FIFO routes in-order read returns back.
module sp_dram_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int TAG_DEPTH  = 16,
  parameter int TAG_AW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  sp_dram_arbiter_if.slave    p0,
  sp_dram_arbiter_if.slave    p1,
  sp_dram_arbiter_if.master   mem,
  output logic [TAG_AW:0]     rd_pending,
  output logic                err
);
  localparam logic [TAG_AW:0] TAG_LIMIT = (TAG_AW+1)'(TAG_DEPTH);

  logic [1:0]            req_we;
  logic [1:0]            req_re;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [MASK_WIDTH-1:0] req_mask  [2];

  logic [1:0]            pend_q, pend_d;
  logic [1:0]            op_we_q, op_we_d;
  logic [ADDR_WIDTH-1:0] addr_q [2], addr_d [2];
  logic [DATA_WIDTH-1:0] wdata_q [2], wdata_d [2];
  logic [MASK_WIDTH-1:0] mask_q [2], mask_d [2];
  logic [DATA_WIDTH-1:0] rdata_q [2], rdata_d [2];
  logic [1:0]            ravail_q, ravail_d;
  logic                  rr_last_q, rr_last_d;
  logic [TAG_DEPTH-1:0]  tag_mem_q, tag_mem_d;
  logic [TAG_AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [TAG_AW:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [1:0]            elig;
  logic                  gnt;
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign req_we[0]    = p0.we;
  assign req_we[1]    = p1.we;
  assign req_re[0]    = p0.re;
  assign req_re[1]    = p1.re;
  assign req_addr[0]  = p0.addr;
  assign req_addr[1]  = p1.addr;
  assign req_wdata[0] = p0.wdata;
  assign req_wdata[1] = p1.wdata;
  assign req_mask[0]  = p0.mask;
  assign req_mask[1]  = p1.mask;

  // A read may only issue while a tag slot is free (registered count only).
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = pend_q[i] & (op_we_q[i] | (cnt_q < TAG_LIMIT));
    end
    gnt   = (elig == 2'b11) ? ~rr_last_q : elig[1];
    issue = (|elig) & ~mem.full & ~rst;
    push  = issue & ~op_we_q[gnt];
    pop   = mem.ravail & (cnt_q != '0);
  end

  for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
    assign tag_mem_d[gi] = (push && (wr_ptr_q == TAG_AW'(gi))) ? gnt : tag_mem_q[gi];
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pend_d[i]   = pend_q[i];
      op_we_d[i]  = op_we_q[i];
      addr_d[i]   = addr_q[i];
      wdata_d[i]  = wdata_q[i];
      mask_d[i]   = mask_q[i];
      rdata_d[i]  = rdata_q[i];
      ravail_d[i] = 1'b0;
      if (issue && (gnt == i[0])) begin
        pend_d[i] = 1'b0;
      end
      if (!pend_q[i] && (req_we[i] || req_re[i])) begin
        pend_d[i]  = 1'b1;
        op_we_d[i] = req_we[i];
        addr_d[i]  = req_addr[i];
        wdata_d[i] = req_wdata[i];
        mask_d[i]  = req_mask[i];
      end
      if (pop && (tag_mem_q[rd_ptr_q] == i[0])) begin
        rdata_d[i]  = mem.rdata;
        ravail_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_last_d = issue ? gnt : rr_last_q;
    wr_ptr_d  = wr_ptr_q + TAG_AW'(push);
    rd_ptr_d  = rd_ptr_q + TAG_AW'(pop);
    cnt_d     = cnt_q + (TAG_AW+1)'(push) - (TAG_AW+1)'(pop);
    err_d     = err_q | (mem.ravail & (cnt_q == '0));
  end

  // rr_last resets to P1 so that P0 wins the first two-way contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      ravail_q  <= '0;
      rr_last_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '{default: '0};
    end else begin
      pend_q    <= pend_d;
      ravail_q  <= ravail_d;
      rr_last_q <= rr_last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    op_we_q   <= op_we_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    mask_q    <= mask_d;
    tag_mem_q <= tag_mem_d;
  end

  assign mem.we    = issue & op_we_q[gnt];
  assign mem.re    = push;
  assign mem.addr  = addr_q[gnt];
  assign mem.wdata = wdata_q[gnt];
  assign mem.mask  = mask_q[gnt];

  assign p0.full   = rst | pend_q[0];
  assign p1.full   = rst | pend_q[1];
  assign p0.rdata  = rdata_q[0];
  assign p1.rdata  = rdata_q[1];
  assign p0.ravail = ravail_q[0];
  assign p1.ravail = ravail_q[1];

  assign rd_pending = cnt_q;
  assign err        = err_q;
endmodule

// File: tb/tb_sp_dram_arbiter.sv
// Randomized scoreboard bench for sp_dram_arbiter: the driver queues each accepted
// request, a negedge monitor predicts issue order, read routing and counters.
module tb_sp_dram_arbiter;
  localparam int AW = 25;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int TD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) p0_if ();
  sp_dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) p1_if ();
  sp_dram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) mem_if ();

  logic [4:0] rd_pending;
  logic       err;

  sp_dram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_DEPTH(TD), .TAG_AW(4)
  ) dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if), .mem(mem_if),
    .rd_pending(rd_pending), .err(err)
  );

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
  } req_t;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
  } ret_t;

  // Driver-side signals
  logic          drv_we [2]    = '{1'b0, 1'b0};
  logic          drv_re [2]    = '{1'b0, 1'b0};
  logic [AW-1:0] drv_addr [2]  = '{'0, '0};
  logic [DW-1:0] drv_wdata [2] = '{'0, '0};
  logic [MW-1:0] drv_mask [2]  = '{'0, '0};
  bit            drv_req [2]   = '{1'b0, 1'b0};
  req_t          drv_item [2];
  logic          drv_mfull     = 1'b0;
  logic          drv_mravail   = 1'b0;
  logic [DW-1:0] drv_mrdata    = '0;
  int            mem_returned  = 0;

  assign p0_if.we    = drv_we[0];
  assign p1_if.we    = drv_we[1];
  assign p0_if.re    = drv_re[0];
  assign p1_if.re    = drv_re[1];
  assign p0_if.addr  = drv_addr[0];
  assign p1_if.addr  = drv_addr[1];
  assign p0_if.wdata = drv_wdata[0];
  assign p1_if.wdata = drv_wdata[1];
  assign p0_if.mask  = drv_mask[0];
  assign p1_if.mask  = drv_mask[1];
  assign mem_if.full   = drv_mfull;
  assign mem_if.ravail = drv_mravail;
  assign mem_if.rdata  = drv_mrdata;

  logic [1:0]    p_full;
  logic [1:0]    p_rav;
  logic [DW-1:0] p_rdata [2];
  assign p_full     = {p1_if.full, p0_if.full};
  assign p_rav      = {p1_if.ravail, p0_if.ravail};
  assign p_rdata[0] = p0_if.rdata;
  assign p_rdata[1] = p1_if.rdata;

  // Scoreboard / reference model state
  req_t req_q [2][$];
  int   tags [$];
  ret_t exp_ret [$];
  int   m_cnt = 0;
  int   m_last = 1;
  bit   m_err = 1'b0;
  int   mem_issued = 0;
  int   max_seen = 0;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : mon
    bit        el [2];
    int        g;
    int        t;
    req_t      r;
    ret_t      rr;
    logic [1:0] oh;
    if (rst) begin
      chk("full_in_reset_p0", p_full[0], 1'b1);
      chk("full_in_reset_p1", p_full[1], 1'b1);
      req_q[0].delete();
      req_q[1].delete();
      tags.delete();
      exp_ret.delete();
      m_cnt  = 0;
      m_last = 1;
      m_err  = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("full_p%0d", p), p_full[p], (req_q[p].size() != 0));
      end
      chk("rd_pending", rd_pending, m_cnt);
      chk("err", err, m_err);
      if (int'(rd_pending) > max_seen) max_seen = int'(rd_pending);

      // read returns: every routed return must appear exactly one cycle later
      if (exp_ret.size() != 0) begin
        rr = exp_ret.pop_front();
        oh = (rr.port == 1) ? 2'b10 : 2'b01;
        chk("ravail_route", p_rav, oh);
        chk("rdata", p_rdata[rr.port], rr.data);
        $display("[TB] return p%0d data=%h", rr.port, rr.data);
      end else begin
        chk("ravail_idle", p_rav, 2'b00);
      end

      // issue: one eligible port wins; with both, the one not served last
      for (int p = 0; p < 2; p++) begin
        el[p] = (req_q[p].size() != 0) && (req_q[p][0].we || (m_cnt < TD));
      end
      if ((el[0] || el[1]) && !mem_if.full) begin
        if (el[0] && el[1]) g = (m_last == 0) ? 1 : 0;
        else                g = el[1] ? 1 : 0;
        r = req_q[g].pop_front();
        chk("mem_we", mem_if.we, r.we);
        chk("mem_re", mem_if.re, !r.we);
        chk("mem_addr", mem_if.addr, r.addr);
        if (r.we) begin
          chk("mem_wdata", mem_if.wdata, r.wdata);
          chk("mem_mask", mem_if.mask, r.mask);
        end else begin
          tags.push_back(g);
          m_cnt++;
          mem_issued++;
        end
        m_last = g;
        $display("[TB] issue p%0d we=%0d addr=%h", g, r.we, r.addr);
      end else begin
        chk("idle_mem_we", mem_if.we, 1'b0);
        chk("idle_mem_re", mem_if.re, 1'b0);
      end

      if (mem_if.ravail) begin
        if (tags.size() != 0) begin
          t = tags.pop_front();
          exp_ret.push_back('{port: t, data: mem_if.rdata});
          m_cnt--;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic run(input int cyc, input int req_pct, input int rd_pct,
                     input int ret_pct, input int full_pct, input bit do_rst);
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      for (int p = 0; p < 2; p++) begin
        if (drv_req[p]) req_q[p].push_back(drv_item[p]);
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        drv_req[p]   = 1'b0;
        drv_we[p]    = 1'b0;
        drv_re[p]    = 1'b0;
        drv_addr[p]  = AW'($urandom());
        drv_wdata[p] = {$urandom(), $urandom(), $urandom(), $urandom()};
        drv_mask[p]  = MW'($urandom());
        if (!do_rst && !p_full[p] && ($urandom_range(99) < req_pct)) begin
          drv_req[p] = 1'b1;
          if ($urandom_range(99) < rd_pct) begin
            drv_re[p] = 1'b1;
          end else begin
            drv_we[p] = 1'b1;
            drv_re[p] = ($urandom_range(7) == 0);
          end
          drv_item[p] = '{we: drv_we[p], addr: drv_addr[p],
                          wdata: drv_wdata[p], mask: drv_mask[p]};
        end
      end
      drv_mfull   = ($urandom_range(99) < full_pct);
      drv_mravail = 1'b0;
      drv_mrdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!do_rst && (mem_issued > mem_returned) && ($urandom_range(99) < ret_pct)) begin
        drv_mravail = 1'b1;
        mem_returned++;
      end
      rst = do_rst;
    end
  endtask

  initial begin
    run(4,   0,   0,   0,   0,   1'b1);
    run(300, 50,  50,  40,  20,  1'b0);
    run(20,  90,  50,  0,   100, 1'b0);
    run(60,  80,  100, 0,   0,   1'b0);
    run(150, 50,  50,  60,  10,  1'b0);
    run(20,  60,  100, 0,   0,   1'b0);
    run(3,   0,   0,   0,   0,   1'b1);
    run(30,  0,   0,   100, 0,   1'b0);
    run(200, 50,  50,  50,  20,  1'b0);
    run(60,  0,   0,   100, 0,   1'b0);
    @(negedge clk);
    #1;
    chk("max_rd_pending", max_seen, TD);
    chk("err_sticky_after_stray", err, 1'b1);
    chk("drained_rd_pending", rd_pending, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
